osc_clken_gen: RTL and testbench

Parametrised multi-channel clock-enable generator that runs on the fabric oscillator clock (RCOSC_25_50MHZ_O2F after CLKINT). It replaces ad-hoc per-consumer dividers with NUM_CH independently programmable, glitch-free, single-cycle enable strobes. It also provides an oscillator settle window and a phase-align command. All downstream logic stays on one global clock and uses CLKEN_OUT as enables.

---
 rtl/osc_clken_gen.sv | 132 +++++++++++++
 tb/tb_osc_clken_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/osc_clken_gen.sv
// osc_clken_gen
// Multi-channel clock-enable generator on the fabric oscillator clock.
// After reset a settle window runs; once OSC_READY is high, each enabled
// channel produces a one-cycle CLKEN_OUT strobe every (div+1) cycles.
// Divider changes are staged in a per-channel shadow register. They take
// effect at a period boundary, or on the next edge if the channel is idle.
// A SYNC pulse re-phases all channel counters.
module osc_clken_gen #(
  parameter int NUM_CH        = 4,
  parameter int DIV_W         = 16,
  parameter int DEFAULT_DIV   = 49,
  parameter int SETTLE_CYCLES = 1024,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] CH_EN,
  input  logic              SYNC,
  input  logic              DIV_LOAD,
  input  logic [CH_W-1:0]   DIV_CH,
  input  logic [DIV_W-1:0]  DIV_VALUE,
  output logic              DIV_ACK,
  output logic              OSC_READY,
  output logic [NUM_CH-1:0] CLKEN_OUT
);

  // Settle window state
  logic [SET_W-1:0]  settle_cnt_reg;
  logic              ready_reg;

  // Per-channel results gathered from the generate loop
  logic [NUM_CH-1:0] clken_vec;
  logic [NUM_CH-1:0] apply_vec;

  // Acknowledge pipeline: apply edge -> flag -> DIV_ACK one edge later
  logic              apply_any_reg;
  logic              div_ack_reg;

  // Settle counter: count up after reset, then latch ready until next reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      settle_cnt_reg <= '0;
      ready_reg      <= 1'b0;
    end else if (!ready_reg) begin
      if (settle_cnt_reg == SET_W'(SETTLE_CYCLES - 1)) begin
        ready_reg <= 1'b1;
      end else begin
        settle_cnt_reg <= settle_cnt_reg + 1'b1;
      end
    end
  end

  // Register the OR of all divider applications, then emit the ack pulse
  always_ff @(posedge CLK) begin
    if (RESET) begin
      apply_any_reg <= 1'b0;
      div_ack_reg   <= 1'b0;
    end else begin
      apply_any_reg <= |apply_vec;
      div_ack_reg   <= apply_any_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DIV_W-1:0] cnt_reg, cnt_next;
      logic [DIV_W-1:0] div_reg, div_next;
      logic [DIV_W-1:0] shadow_reg, shadow_next;
      logic             pend_reg, pend_next;
      logic             clken_reg, clken_next;
      logic             active;
      logic             terminal;
      logic             load_hit;
      logic             apply;

      // Next-state logic for one channel.
      // Counter and strobe first. SYNC outranks the terminal count.
      // Divider staging second. An active channel only swaps its divider at
      // the terminal count, so a period never mixes old and new values.
      always_comb begin
        active   = ready_reg & CH_EN[gi];
        terminal = (cnt_reg == div_reg);
        // An in-range DIV_CH can only match an existing channel, so
        // out-of-range loads fall through silently.
        load_hit = DIV_LOAD & (DIV_CH == CH_W'(gi));
        apply    = pend_reg & (active ? (~SYNC & terminal) : 1'b1);

        cnt_next   = '0;
        clken_next = 1'b0;
        if (active && !SYNC) begin
          if (terminal) begin
            clken_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end

        div_next    = apply ? shadow_reg : div_reg;
        shadow_next = load_hit ? DIV_VALUE : shadow_reg;
        // A load on the same edge as an apply re-arms the shadow
        pend_next   = load_hit | (pend_reg & ~apply);
      end

      // Channel state registers
      always_ff @(posedge CLK) begin
        if (RESET) begin
          cnt_reg    <= '0;
          div_reg    <= DIV_W'(DEFAULT_DIV);
          shadow_reg <= DIV_W'(DEFAULT_DIV);
          pend_reg   <= 1'b0;
          clken_reg  <= 1'b0;
        end else begin
          cnt_reg    <= cnt_next;
          div_reg    <= div_next;
          shadow_reg <= shadow_next;
          pend_reg   <= pend_next;
          clken_reg  <= clken_next;
        end
      end

      assign clken_vec[gi] = clken_reg;
      assign apply_vec[gi] = apply;
    end
  endgenerate

  assign CLKEN_OUT = clken_vec;
  assign OSC_READY = ready_reg;
  assign DIV_ACK   = div_ack_reg;

endmodule

// File: tb/tb_osc_clken_gen.sv
// tb_osc_clken_gen
// Directed bench for osc_clken_gen. The main instance uses 4 channels,
// SETTLE_CYCLES=8 and DEFAULT_DIV=49. A second instance with 3 channels
// covers an out-of-range DIV_CH, which a 2-bit index cannot express on 4 channels.
// n counts clock edges since reset release. Every expected value below is
// a hand-derived edge number.
module tb_osc_clken_gen;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance signals
  logic       reset;
  logic [3:0] ch_en;
  logic       sync;
  logic       div_load;
  logic [1:0] div_ch;
  logic [15:0] div_value;
  logic       div_ack;
  logic       osc_ready;
  logic [3:0] clken;

  // Second instance signals
  logic       reset2;
  logic [2:0] ch_en2;
  logic       sync2;
  logic       load2;
  logic [1:0] div_ch2;
  logic [7:0] div_value2;
  logic       ack2;
  logic       ready2;
  logic [2:0] clken2;

  int checks   = 0;
  int failures = 0;
  int n        = 0;
  int base     = 0;

  osc_clken_gen #(
    .NUM_CH(4), .DIV_W(16), .DEFAULT_DIV(49), .SETTLE_CYCLES(8)
  ) dut (
    .CLK(clk), .RESET(reset), .CH_EN(ch_en), .SYNC(sync),
    .DIV_LOAD(div_load), .DIV_CH(div_ch), .DIV_VALUE(div_value),
    .DIV_ACK(div_ack), .OSC_READY(osc_ready), .CLKEN_OUT(clken)
  );

  osc_clken_gen #(
    .NUM_CH(3), .DIV_W(8), .DEFAULT_DIV(2), .SETTLE_CYCLES(1)
  ) dut2 (
    .CLK(clk), .RESET(reset2), .CH_EN(ch_en2), .SYNC(sync2),
    .DIV_LOAD(load2), .DIV_CH(div_ch2), .DIV_VALUE(div_value2),
    .DIV_ACK(ack2), .OSC_READY(ready2), .CLKEN_OUT(clken2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; ch_en = 4'b1111; sync = 1'b0;
    div_load = 1'b0; div_ch = 2'd0; div_value = 16'd0;
    reset2 = 1'b1; ch_en2 = 3'b111; sync2 = 1'b0;
    load2 = 1'b0; div_ch2 = 2'd0; div_value2 = 8'd0;

    // Reset state
    tick();
    check("rst_ready", 32'(osc_ready), 32'd0);
    check("rst_clken", 32'(clken), 32'd0);
    check("rst_ack", 32'(div_ack), 32'd0);
    tick();
    check("rst_clken2", 32'(clken), 32'd0);
    reset = 1'b0; reset2 = 1'b0; n = 0;

    // Settle window: ready after the 8th edge, no strobes meanwhile
    for (int k = 1; k <= 7; k++) begin
      tick();
      check("settle_ready", 32'(osc_ready), 32'd0);
      check("settle_clken", 32'(clken), 32'd0);
    end
    tick();
    check("ready_edge8", 32'(osc_ready), 32'd1);
    check("ready_edge8_clken", 32'(clken), 32'd0);

    // Default divider 49: strobes at edges 58 and 108
    while (n < 108) begin
      tick();
      check("p1_clken", 32'(clken), (n == 58 || n == 108) ? 32'hF : 32'h0);
      check("p1_ack", 32'(div_ack), 32'd0);
    end

    // Load ch1=3 mid-period (edge 111). It applies at the terminal count on
    // edge 158, the ack follows on 159, and ch1 then strobes every 4 edges.
    tick(); tick();
    div_load = 1'b1; div_ch = 2'd1; div_value = 16'd3;
    tick();
    div_load = 1'b0;
    while (n < 170) begin
      tick();
      check("p2_ack", 32'(div_ack), (n == 159) ? 32'd1 : 32'd0);
      check("p2_ch1", 32'(clken[1]),
            (n == 158 || n == 162 || n == 166 || n == 170) ? 32'd1 : 32'd0);
      check("p2_ch0", 32'(clken[0]), (n == 158) ? 32'd1 : 32'd0);
    end

    // Ch2 div=0 while disabled: shadow on 171, apply on 172, ack on 173
    ch_en[2] = 1'b0;
    div_load = 1'b1; div_ch = 2'd2; div_value = 16'd0;
    tick();
    div_load = 1'b0;
    check("p3_ch2_off", 32'(clken[2]), 32'd0);
    tick();
    check("p3_ack_early", 32'(div_ack), 32'd0);
    tick();
    check("p3_ack", 32'(div_ack), 32'd1);
    ch_en[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("p3_ch2_const", 32'(clken[2]), 32'd1);
    end
    ch_en[2] = 1'b0;
    tick();
    check("p3_ch2_drop", 32'(clken[2]), 32'd0);
    ch_en[2] = 1'b1;
    tick();
    check("p3_ch2_back", 32'(clken[2]), 32'd1);

    // Ch0 and ch3 to div=4 while disabled. Back-to-back loads give acks on 181 and 182.
    ch_en[0] = 1'b0; ch_en[3] = 1'b0;
    div_load = 1'b1; div_ch = 2'd0; div_value = 16'd4;
    tick();
    div_ch = 2'd3;
    tick();
    div_load = 1'b0;
    tick();
    check("p4_ack0", 32'(div_ack), 32'd1);
    ch_en[0] = 1'b1;
    tick();
    check("p4_ack3", 32'(div_ack), 32'd1);
    tick();
    check("p4_ack_end", 32'(div_ack), 32'd0);
    ch_en[3] = 1'b1;
    // Different phases: ch0 strobes on 186, ch3 on 188
    while (n < 190) begin
      tick();
      check("p4_ch0_phase", 32'(clken[0]), (n == 186) ? 32'd1 : 32'd0);
      check("p4_ch3_phase", 32'(clken[3]), (n == 188) ? 32'd1 : 32'd0);
    end
    // SYNC on edge 191, which is ch0's terminal count, so no strobe
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("p4_sync_tc_ch0", 32'(clken[0]), 32'd0);
    check("p4_sync_tc_ch3", 32'(clken[3]), 32'd0);
    while (n < 201) begin
      tick();
      check("p4_ch0_synced", 32'(clken[0]), (n == 196 || n == 201) ? 32'd1 : 32'd0);
      check("p4_ch3_synced", 32'(clken[3]), (n == 196 || n == 201) ? 32'd1 : 32'd0);
    end

    // Two loads to ch1 (7 then 2) before its terminal count on edge 207.
    // Period becomes 3 and exactly one ack appears, on edge 208.
    tick(); tick();
    check("p5_ch1_pre", 32'(clken[1]), 32'd1);
    div_load = 1'b1; div_ch = 2'd1; div_value = 16'd7;
    tick();
    div_value = 16'd2;
    tick();
    div_load = 1'b0;
    while (n < 216) begin
      tick();
      check("p5_ack", 32'(div_ack), (n == 208) ? 32'd1 : 32'd0);
      check("p5_ch1", 32'(clken[1]),
            (n == 207 || n == 210 || n == 213 || n == 216) ? 32'd1 : 32'd0);
    end

    // Out-of-range index on the 3-channel instance: ignored, no ack, period 3 kept
    check("oor_ready", 32'(ready2), 32'd1);
    load2 = 1'b1; div_ch2 = 2'd3; div_value2 = 8'd0;
    tick();
    load2 = 1'b0;
    while (n < 229) begin
      tick();
      check("oor_ack", 32'(ack2), 32'd0);
      check("oor_clken", 32'(clken2), (n % 3 == 1) ? 32'h7 : 32'h0);
    end

    // Reset while a ch0 load is pending and strobes are running
    while (n < 231) tick();
    check("p6_ch0_tc", 32'(clken[0]), 32'd1);
    div_load = 1'b1; div_ch = 2'd0; div_value = 16'd10;
    tick();
    div_load = 1'b0;
    tick();
    check("p6_pre_reset", 32'(clken), 32'h4);
    reset = 1'b1;
    tick();
    check("p6_rst_clken", 32'(clken), 32'd0);
    check("p6_rst_ready", 32'(osc_ready), 32'd0);
    check("p6_rst_ack", 32'(div_ack), 32'd0);
    reset = 1'b0;
    base = n;
    while (n - base < 60) begin
      tick();
      check("p6_ack", 32'(div_ack), 32'd0);
      check("p6_ready", 32'(osc_ready), (n - base >= 8) ? 32'd1 : 32'd0);
      check("p6_clken", 32'(clken), (n - base == 58) ? 32'hF : 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
